// File: rtl/pipe_ctrl_n_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The slave modport is the controller's view; master is the datapath/bench view.
interface pipe_ctrl_n_if #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned IDX_W  = $clog2(STAGES),
    parameter int unsigned CNT_W  = 32
);
    logic [STAGES-1:0] stall_req;
    logic              flush_req;
    logic [IDX_W-1:0]  flush_idx;
    logic              drain_req;
    logic              pc_stall;
    logic              redirect;
    logic [STAGES-2:0] stall;
    logic [STAGES-2:0] bubble;
    logic [STAGES-2:0] vld;
    logic              drained;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output stall_req, flush_req, flush_idx, drain_req,
        input  pc_stall, redirect, stall, bubble, vld, drained,
               stall_cycles, flush_count
    );

    modport slave (
        input  stall_req, flush_req, flush_idx, drain_req,
        output pc_stall, redirect, stall, bubble, vld, drained,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: parametrised pipeline hazard controller.
// Turns per-stage stall requests and a redirect into per-register hold/bubble
// controls, tracks per-register valid bits and drains the pipe on request.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_n #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned IDX_W  = $clog2(STAGES),
    parameter int unsigned CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_n_if.slave bus
);
    localparam int unsigned NREG = STAGES - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREG-1:0]  r_vld;
    logic [NREG-1:0]  w_vld_nxt;
    logic [IDX_W-1:0] w_hi;
    logic             w_any_stall;
    logic             w_flush_acc;
    logic             w_draining;
    logic             w_fetch_en;
    logic [NREG-1:0]  w_stall_rule;
    logic [NREG-1:0]  w_bubble;
    logic [NREG-1:0]  w_stall;
    logic [NREG-1:0]  w_src;
    logic             w_pc_stall;
    logic             w_redirect;

    assign w_any_stall = |bus.stall_req;
    assign w_flush_acc = bus.flush_req && (bus.flush_idx != '0) &&
                         (32'(bus.flush_idx) < STAGES);

    // Drain gating starts in the cycle drain_req is first seen (PC held, register 0
    // bubbled) so the pipe empties within STAGES cycles without losing a fetch.
    assign w_draining  = (r_state == ST_DRAIN) || ((r_state == ST_IDLE) && bus.drain_req);
    assign w_fetch_en  = (r_state == ST_IDLE) && !bus.drain_req;

    // Locate the oldest (highest-index) stalled stage; later hits overwrite earlier ones.
    always_comb begin
        w_hi = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (bus.stall_req[i]) begin
                w_hi = IDX_W'(i);
            end
        end
    end

    // Per-register hold/bubble: bubble beats stall; reset forces a bubble everywhere.
    always_comb begin
        w_stall_rule = '0;
        w_bubble     = '0;
        for (int unsigned j = 0; j < NREG; j++) begin
            w_stall_rule[j] = w_any_stall && (IDX_W'(j) < w_hi);
            w_bubble[j]     = (w_any_stall && (IDX_W'(j) == w_hi)) ||
                              (w_flush_acc && (IDX_W'(j) < bus.flush_idx));
        end
        if ((r_state == ST_HALTED) || (w_draining && !w_stall_rule[0])) begin
            w_bubble[0] = 1'b1;
        end
        w_stall    = w_stall_rule & ~w_bubble;
        w_pc_stall = w_any_stall || w_draining || (r_state == ST_HALTED);
        w_redirect = w_flush_acc;
        if (rst) begin
            w_stall    = '0;
            w_bubble   = '1;
            w_pc_stall = 1'b1;
            w_redirect = 1'b0;
        end
    end

    assign w_src = {r_vld[NREG-2:0], ~bus.stall_req[0] & w_fetch_en};

    // Valid bits follow the same bubble > stall > advance priority as the data registers.
    always_comb begin
        w_vld_nxt = '0;
        for (int unsigned j = 0; j < NREG; j++) begin
            if (w_bubble[j]) begin
                w_vld_nxt[j] = 1'b0;
            end else if (w_stall[j]) begin
                w_vld_nxt[j] = r_vld[j];
            end else begin
                w_vld_nxt[j] = w_src[j];
            end
        end
    end

    // Drain FSM next state; a redirect never changes the drain state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.drain_req) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.drain_req) begin
                    w_state_nxt = ST_IDLE;
                end else if ((r_vld == '0) && (bus.stall_req == '0)) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!bus.drain_req) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vld   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_any_stall) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_flush_acc) r_flush_count  <= r_flush_count + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif

    assign bus.stall    = w_stall;
    assign bus.bubble   = w_bubble;
    assign bus.pc_stall = w_pc_stall;
    assign bus.redirect = w_redirect;
    assign bus.vld      = r_vld;
    assign bus.drained  = (r_state == ST_HALTED);
endmodule

// File: doc/pipe_ctrl_n.md
# pipe_ctrl_n

Parametrised pipeline hazard controller for the in-order RISC-V core, replacing the fixed 5-stage combinational stall controller. It turns per-stage stall requests and a branch/exception redirect into per-register hold and bubble controls plus a PC hold. It also tracks which pipeline registers hold valid instructions, and drains the pipeline on request for debug halt or interrupt entry. Optional performance counters are compiled in by macro.

## Interface
Parameters:
- STAGES, 5, number of pipeline stages; there are STAGES-1 pipeline registers; legal range 3..8.
- IDX_W, $clog2(STAGES), width of stage index.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- stall_req  in  STAGES  bit i = stage i cannot complete this cycle (bit 0 = fetch not valid).
- flush_req  in  1  one-cycle pulse; the instruction in stage flush_idx redirects the PC.
- flush_idx  in  IDX_W  redirecting stage, 1..STAGES-1.
- drain_req  in  1  level; request pipeline empty and hold.
- pc_stall  out  1  PC register holds.
- redirect  out  1  PC loads the redirect target this cycle; overrides pc_stall.
- stall  out  STAGES-1  bit j = pipeline register j holds.
- bubble  out  STAGES-1  bit j = pipeline register j loads a NOP (valid 0).
- vld  out  STAGES-1  bit j = register j holds a valid instruction.
- drained  out  1  pipeline empty and held.
- stall_cycles  out  CNT_W  cycles with any stall_req set (perf build only).
- flush_count  out  CNT_W  accepted redirects (perf build only).

## Operation
- Register j sits between stage j and stage j+1.
- Stall rule: h = highest i with stall_req[i]=1.
  - If any stall_req bit is set: pc_stall=1 and stall[j]=1 for all j<h.
  - If h<=STAGES-2, bubble[h]=1.
  - Stalls are per cycle; the controller does not latch them.
- Flush rule: flush_req=1 sets redirect=1 and bubble[j]=1 for all j<flush_idx.
  - Bubble wins over stall for the same register.
  - Registers at or above flush_idx keep the stall rule.
  - flush_idx=0 or flush_idx>=STAGES is ignored: no redirect, no count.
- Precedence per register j: rst > bubble > stall > advance.
- Valid tracking, per cycle:
  - If bubble[j]: vld[j] <= 0.
  - Else if stall[j]: vld[j] holds.
  - Else vld[j] <= source, where source is ~stall_req[0] & fetch_en for j=0 and vld[j-1] for j>0.
  - fetch_en = 0 in DRAIN and HALTED.
- Drain FSM:
  - IDLE: drain_req=1 -> DRAIN.
  - DRAIN: pc_stall=1; bubble[0]=1 unless stall[0].
    - -> HALTED when vld==0 and stall_req==0.
    - -> IDLE if drain_req falls.
  - HALTED: drained=1, pc_stall=1, bubble[0]=1. drain_req=0 -> IDLE.
  - flush_req in DRAIN or HALTED: redirect still fires; the FSM state is unchanged.

## Timing
- stall, bubble, pc_stall and redirect are combinational from same-cycle inputs and state, with zero latency.
- vld, the FSM state, drained and the counters are registered and update on the clk edge.
- Reset, held while rst=1:
  - stall=0, bubble=all 1, pc_stall=1, redirect=0.
  - vld=0, state=IDLE, drained=0, counters=0.
- Drain latency from IDLE with no stalls: drained rises at most STAGES cycles after drain_req rises.
- Counters wrap modulo 2^CNT_W, with no saturation.
- Simultaneous events:
  - flush_req and stall_req in the same cycle: the per-register precedence above decides.
  - drain_req and flush_req in the same cycle: both take effect.
- rst mid-drain: the FSM returns to IDLE and no drained pulse is produced.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments every cycle in which |stall_req and !rst.
  - flush_count increments on every accepted redirect.
- PIPE_CTRL_PERF_EN undefined: stall_cycles and flush_count are constant 0 and no counter flops are built.

## Test plan
All scenarios use STAGES=5.
- Memory stall: stall_req=5'b01000 for 3 cycles -> stall=4'b0111, bubble=4'b1000, pc_stall=1 each cycle. vld[3]=0 after the first edge; vld[2:0] held.
- Fetch miss: stall_req=5'b00001 -> stall=0, bubble=4'b0001, pc_stall=1. vld[0] falls, and the 0 propagates down one register per cycle.
- Branch in EX: flush_req=1, flush_idx=2, stall_req=0 -> redirect=1, bubble=4'b0011. The next cycle vld[1:0]=0; flush_count=1 in the perf build.
- Flush vs older stall: flush_idx=2 with stall_req=5'b01000 -> bubble=4'b1011, stall=4'b0100, redirect=1.
- Drain: full pipe (vld=4'b1111), drain_req=1 held, no stalls -> drained=1 within 5 cycles with vld=0 and pc_stall=1. drain_req=0 -> IDLE next cycle, drained=0.
- Reset: assert rst mid-DRAIN with vld=4'b0110 -> next cycle vld=0, drained=0, bubble=4'b1111, counters 0.
